timer_apb_regs: RTL and testbench
=================================

Name: timer_apb_regs

Overview:
- APB completer (responder) for the 8-bit timer register bank; the far end of the CPU model's apb_write/apb_read tasks.
- Decodes byte addresses 0x00-0x03, holds TDR and TCR, keeps sticky overflow/underflow flags in TSR, and returns the live counter value TCNT.
- Sits between the APB bus and the timer counter core. Inserts programmable wait states and flags bad accesses with pslverr.

Parameters:
- WAIT_CYCLES, 0, number of ACCESS-phase cycles with pready=0 before completion (0..7).
- ADDR_W, 8, paddr width.
- DATA_W, 8, data width. Fixed at 8; other values are not supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (ACCESS phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  8  write data.
- prdata  out  8  read data; valid only while pready=1 on a read.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; valid only while pready=1.
- tdr  out  8  reload/compare data register.
- tcr  out  8  control: [7] load, [5] down, [4] enable, [1:0] clock select; [6], [3:2] forced to 0.
- tcnt  in  8  live counter value from the core.
- ovf_set  in  1  one-cycle pulse from the core on 0xFF->0x00 count-up overflow.
- udf_set  in  1  one-cycle pulse from the core on 0x00->0xFF count-down underflow.
- tsr  out  8  status: [0] OVF, [1] UDF, [7:2] = 0.

Behaviour:
- Reset (asynchronous, active-high): tdr=0x00, tcr=0x00, tsr=0x00, prdata=0x00, pready=0, pslverr=0, FSM=IDLE, wait counter=0.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when psel=1 and penable=0. Register paddr, pwrite and pwdata on this edge; clear the wait counter.
  - ACCESS, psel=1 and penable=1: increment the wait counter until it equals WAIT_CYCLES.
  - pready = (state==ACCESS) & psel & penable & (wcnt==WAIT_CYCLES), decoded combinationally from registers. With WAIT_CYCLES=0 this gives zero-wait APB timing.
  - ACCESS -> IDLE on the completion cycle (pready=1).
  - ACCESS -> IDLE with no commit if psel drops before completion (protocol abort).
- Back-to-back transfers: a new SETUP in the cycle after completion is accepted normally.
- Writes commit at the clock edge that ends the completion cycle:
  - 0x00: tdr <= pwdata.
  - 0x01: tcr <= pwdata & 0xB3.
  - 0x02: TSR is write-1-to-clear. tsr[1:0] <= tsr[1:0] & ~pwdata[1:0].
  - 0x03: read-only. pslverr=1; no state change.
  - Any address > 0x03: pslverr=1; no state change.
- Reads are combinational during the completion cycle:
  - 0x00 -> tdr; 0x01 -> tcr; 0x02 -> tsr; 0x03 -> tcnt sampled in that cycle.
  - Any address > 0x03 -> 0x00 with pslverr=1.
  - Reads have no side effects; TSR is not cleared on read.
- prdata = 0x00 and pslverr = 0 whenever pready = 0.
- TSR flag updates:
  - ovf_set sets tsr[0]; udf_set sets tsr[1]. Flags are sticky until cleared.
  - A set pulse and a W1C of the same bit in the same cycle: set wins, bit stays 1.
- No filtering of the load path in this block. Suppressing a fake overflow on TDR reload (0xFF->0x00 via the load bit) is the core's job; this block records only ovf_set/udf_set.
- tcr[7] is a stored level bit. Software writes 0 to release it.

Decomposition:
- Shared package timer_pkg holds:
  - address constants ADDR_TDR=8'h00, ADDR_TCR=8'h01, ADDR_TSR=8'h02, ADDR_TCNT=8'h03;
  - TCR bit indices LOAD=7, DOWN=5, EN=4, CKS=1:0;
  - TCR_WMASK=8'hB3;
  - TSR bit indices OVF=0, UDF=1;
  - FSM state enum.
- One natural sub-module: apb_wait_ctrl, containing the IDLE/ACCESS FSM, wait counter and pready generation. The decode and register storage stay in timer_apb_regs.

Test Plan:
- Reset, then read 0x00, 0x01, 0x02 -> 0x00 each, pslverr=0, pready on the first ACCESS cycle (WAIT_CYCLES=0).
- Write TDR=0xFF, then TCR=0x90; read back -> 0xFF and 0x90. Write TCR=0xFF -> read 0xB3.
- Pulse ovf_set once, read TSR -> 0x01. Write TSR=0x01, read -> 0x00. Write ovf_set and W1C 0x01 in the same cycle -> TSR reads 0x01.
- Write TDR=0xFF with TCR=0x80, then TDR=0x00 with TCR=0x80, with no ovf_set pulse -> TSR reads 0x00 (fake-overflow guard).
- Write 0x03 and write/read 0x10 -> pslverr=1, read returns 0x00, TDR/TCR/TSR unchanged. Drive tcnt=0x5A, read 0x03 -> 0x5A.
- WAIT_CYCLES=3: pready stays low for exactly 3 ACCESS cycles, then is high for 1. Drop psel mid-ACCESS on a TDR write of 0x77 -> TDR unchanged. Assert rst mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer register bank.
// Holds the register map, the TCR/TSR bit positions, the TCR write mask
// and the APB completer FSM state type.
package timer_pkg;

  // Byte addresses of the register bank.
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  // TCR bit positions.
  localparam int LOAD    = 7;
  localparam int DOWN    = 5;
  localparam int EN      = 4;
  localparam int CKS_MSB = 1;
  localparam int CKS_LSB = 0;

  // Bits [6] and [3:2] of TCR do not exist and always read back as 0.
  localparam logic [7:0] TCR_WMASK = 8'hB3;

  // TSR bit positions.
  localparam int OVF = 0;
  localparam int UDF = 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } apb_state_t;

endpackage

// File: rtl/timer_apb_regs_if.sv
// APB bus bundle between the CPU-side requester and the timer register bank.
//   psel/penable/pwrite/paddr/pwdata : requester -> completer
//   prdata/pready/pslverr            : completer -> requester
interface timer_apb_regs_if #(
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_ctrl.sv
// IDLE/ACCESS transfer sequencer for an APB completer.
//   clk, rst    : clock, asynchronous active-high reset
//   psel,penable: APB control inputs
//   setup       : high in the SETUP cycle being accepted; the parent
//                 captures address/direction/data on this edge
//   pready      : completion strobe after WAIT_CYCLES stalled ACCESS cycles
module apb_wait_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  output logic setup,
  output logic pready
);

  localparam logic [2:0] WAIT_LIM = 3'(WAIT_CYCLES);

  apb_state_t state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    setup   = 1'b0;
    pready  = (state_q == ST_ACCESS) && psel && penable && (wcnt_q == WAIT_LIM);

    unique case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          setup   = 1'b1;
          state_d = ST_ACCESS;
          wcnt_d  = '0;
        end
      end
      ST_ACCESS: begin
        if (!psel || pready) begin
          // Completion, or the requester abandoned the transfer.
          state_d = ST_IDLE;
        end else if (penable) begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/timer_apb_regs.sv
// APB completer for the 8-bit timer register bank.
//   clk, rst         : clock, asynchronous active-high reset
//   bus (slave)      : APB psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr
//   tdr, tcr         : reload/compare and control registers to the core
//   tcnt             : live counter value, returned at address 0x03
//   ovf_set, udf_set : one-cycle flag pulses from the core
//   tsr              : sticky status flags, write-1-to-clear
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  timer_apb_regs_if.slave   bus,
  output logic [DATA_W-1:0] tdr,
  output logic [DATA_W-1:0] tcr,
  input  logic [DATA_W-1:0] tcnt,
  input  logic              ovf_set,
  input  logic              udf_set,
  output logic [DATA_W-1:0] tsr
);

  logic              setup, pready;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [7:0]        wdata_q;
  logic [7:0]        reg_addr;
  logic              err, wr_commit;
  logic [7:0]        tsr_d;

  apb_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .psel    (bus.psel),
    .penable (bus.penable),
    .setup   (setup),
    .pready  (pready)
  );

  // Any address outside the bank collapses onto 0xFF so a single case
  // statement covers both the map and the out-of-range error.
  assign reg_addr  = (addr_q[ADDR_W-1:2] == '0) ? {6'd0, addr_q[1:0]} : 8'hFF;
  assign err       = (reg_addr == 8'hFF) || (write_q && reg_addr == ADDR_TCNT);
  assign wr_commit = pready && write_q && !err;

  assign bus.pready  = pready;
  assign bus.pslverr = pready && err;

  always_comb begin
    bus.prdata = 8'h00;
    if (pready && !write_q) begin
      unique case (reg_addr)
        ADDR_TDR:  bus.prdata = tdr;
        ADDR_TCR:  bus.prdata = tcr;
        ADDR_TSR:  bus.prdata = tsr;
        ADDR_TCNT: bus.prdata = tcnt;
        default:   bus.prdata = 8'h00;
      endcase
    end
  end

  // Clear first, then set: a flag pulse in the same cycle as a W1C wins.
  always_comb begin
    tsr_d = tsr;
    if (wr_commit && reg_addr == ADDR_TSR) begin
      tsr_d[UDF:OVF] = tsr[UDF:OVF] & ~wdata_q[UDF:OVF];
    end
    if (ovf_set) tsr_d[OVF] = 1'b1;
    if (udf_set) tsr_d[UDF] = 1'b1;
  end

  // NOTE: the captured request is reset along with the registers; these are
  // a few flops, not a memory, so resetting them costs nothing and keeps
  // decode outputs defined from the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 8'h00;
      tdr     <= 8'h00;
      tcr     <= 8'h00;
      tsr     <= 8'h00;
    end else begin
      if (setup) begin
        addr_q  <= bus.paddr;
        write_q <= bus.pwrite;
        wdata_q <= bus.pwdata;
      end
      if (wr_commit && reg_addr == ADDR_TDR) tdr <= wdata_q;
      if (wr_commit && reg_addr == ADDR_TCR) tcr <= wdata_q & TCR_WMASK;
      tsr <= tsr_d;
    end
  end

endmodule

// File: tb/tb_timer_apb_regs.sv
// Self-checking bench for timer_apb_regs: one instance with zero wait states
// (index 0) and one with three (index 1), each on its own APB bus, checked
// against a register-map model kept in plain arrays.
module tb_timer_apb_regs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       psel_d    [2];
  logic       penable_d [2];
  logic       pwrite_d  [2];
  logic [7:0] paddr_d   [2];
  logic [7:0] pwdata_d  [2];

  logic [7:0] tcnt;
  logic       ovf_set, udf_set;
  logic [7:0] tdr0, tcr0, tsr0, tdr3, tcr3, tsr3;

  timer_apb_regs_if #(.ADDR_W(8)) bus0 ();
  timer_apb_regs_if #(.ADDR_W(8)) bus3 ();

  assign bus0.psel    = psel_d[0];
  assign bus0.penable = penable_d[0];
  assign bus0.pwrite  = pwrite_d[0];
  assign bus0.paddr   = paddr_d[0];
  assign bus0.pwdata  = pwdata_d[0];
  assign bus3.psel    = psel_d[1];
  assign bus3.penable = penable_d[1];
  assign bus3.pwrite  = pwrite_d[1];
  assign bus3.paddr   = paddr_d[1];
  assign bus3.pwdata  = pwdata_d[1];

  timer_apb_regs #(.WAIT_CYCLES(0), .ADDR_W(8), .DATA_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .tdr(tdr0), .tcr(tcr0), .tcnt(tcnt),
    .ovf_set(ovf_set), .udf_set(udf_set), .tsr(tsr0)
  );

  timer_apb_regs #(.WAIT_CYCLES(3), .ADDR_W(8), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .tdr(tdr3), .tcr(tcr3), .tcnt(tcnt),
    .ovf_set(ovf_set), .udf_set(udf_set), .tsr(tsr3)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register contents per instance.
  logic [7:0] m_tdr [2];
  logic [7:0] m_tcr [2];
  logic [7:0] m_tsr [2];
  int         m_wait [2] = '{0, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_ready(int w);
    return (w == 0) ? bus0.pready : bus3.pready;
  endfunction
  function automatic logic [7:0] o_rdata(int w);
    return (w == 0) ? bus0.prdata : bus3.prdata;
  endfunction
  function automatic logic o_err(int w);
    return (w == 0) ? bus0.pslverr : bus3.pslverr;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_tdr[i] = 8'h00; m_tcr[i] = 8'h00; m_tsr[i] = 8'h00;
    end
  endfunction

  function automatic logic model_err(logic wr, logic [7:0] addr);
    return (addr > 8'h03) || (wr && addr == 8'h03);
  endfunction

  function automatic logic [7:0] model_read(int w, logic [7:0] addr);
    case (addr)
      8'h00:   return m_tdr[w];
      8'h01:   return m_tcr[w];
      8'h02:   return m_tsr[w];
      8'h03:   return tcnt;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_write(int w, logic [7:0] addr, logic [7:0] data);
    case (addr)
      8'h00: m_tdr[w] = data;
      8'h01: m_tcr[w] = data & 8'hB3;
      8'h02: m_tsr[w] = m_tsr[w] & ~(data & 8'h03);
      default: ;
    endcase
  endfunction

  function automatic void model_flags(logic o, logic u);
    for (int i = 0; i < 2; i++) m_tsr[i] = m_tsr[i] | {6'd0, u, o};
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_tdr0"}, tdr0, m_tdr[0]);
    check({tag, "_tcr0"}, tcr0, m_tcr[0]);
    check({tag, "_tsr0"}, tsr0, m_tsr[0]);
    check({tag, "_tdr3"}, tdr3, m_tdr[1]);
    check({tag, "_tcr3"}, tcr3, m_tcr[1]);
    check({tag, "_tsr3"}, tsr3, m_tsr[1]);
  endtask

  // Full APB transfer on bus w. Optionally raises ovf_set during the
  // completion cycle so it coincides with the commit edge.
  task automatic xfer(input int w, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, input bit ovf_on_done);
    logic [7:0] rdata;
    logic       err;
    int         cycles;
    bit         done;
    logic [7:0] exp_rd;
    rdata = 8'h00; err = 1'b0; cycles = 0; done = 0;
    @(posedge clk); #1;
    psel_d[w] = 1'b1; penable_d[w] = 1'b0;
    pwrite_d[w] = wr; paddr_d[w] = addr; pwdata_d[w] = data;
    @(posedge clk); #1;
    penable_d[w] = 1'b1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (o_ready(w)) begin
        done  = 1;
        rdata = o_rdata(w);
        err   = o_err(w);
        exp_rd = model_read(w, addr);
        if (ovf_on_done) ovf_set = 1'b1;
      end
      @(posedge clk); #1;
      ovf_set = 1'b0;
    end
    psel_d[w] = 1'b0; penable_d[w] = 1'b0;
    check($sformatf("done_w%0d_a%0h", w, addr), done, 1);
    check($sformatf("lat_w%0d_a%0h", w, addr), cycles, m_wait[w] + 1);
    check($sformatf("err_w%0d_a%0h", w, addr), err, model_err(wr, addr));
    if (!wr) check($sformatf("rd_w%0d_a%0h", w, addr), rdata, exp_rd);
    else     check($sformatf("wrd_w%0d_a%0h", w, addr), rdata, 0);
    if (wr && !model_err(wr, addr)) model_write(w, addr, data);
    if (ovf_on_done) model_flags(1'b1, 1'b0);
  endtask

  task automatic pulse(input logic o, input logic u);
    @(posedge clk); #1;
    ovf_set = o; udf_set = u;
    @(posedge clk); #1;
    ovf_set = 1'b0; udf_set = 1'b0;
    model_flags(o, u);
  endtask

  initial begin
    logic [7:0] a, d;
    int         sel;
    for (int i = 0; i < 2; i++) begin
      psel_d[i] = 0; penable_d[i] = 0; pwrite_d[i] = 0; paddr_d[i] = 0; pwdata_d[i] = 0;
    end
    tcnt = 8'h00; ovf_set = 0; udf_set = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_pready0", bus0.pready, 0);
    check("rst_prdata0", bus0.prdata, 0);
    check("rst_pslverr0", bus0.pslverr, 0);
    check_ports("rst");

    // Reads of the freshly reset bank.
    xfer(0, 0, 8'h00, 8'h00, 0);
    xfer(0, 0, 8'h01, 8'h00, 0);
    xfer(0, 0, 8'h02, 8'h00, 0);

    // Register write/read-back and TCR masking.
    xfer(0, 1, 8'h00, 8'hFF, 0);
    xfer(0, 1, 8'h01, 8'h90, 0);
    xfer(0, 0, 8'h00, 8'h00, 0);
    xfer(0, 0, 8'h01, 8'h00, 0);
    xfer(0, 1, 8'h01, 8'hFF, 0);
    xfer(0, 0, 8'h01, 8'h00, 0);
    check_ports("wr");

    // Sticky overflow, W1C, and set-wins-over-clear.
    pulse(1, 0);
    xfer(0, 0, 8'h02, 8'h00, 0);
    xfer(0, 1, 8'h02, 8'h01, 0);
    xfer(0, 0, 8'h02, 8'h00, 0);
    xfer(0, 1, 8'h02, 8'h01, 1);
    xfer(0, 0, 8'h02, 8'h00, 0);
    check("set_wins_tsr0", tsr0, 8'h01);

    // Reload through the load bit never raises OVF by itself.
    xfer(0, 1, 8'h02, 8'h03, 0);
    xfer(0, 1, 8'h00, 8'hFF, 0);
    xfer(0, 1, 8'h01, 8'h80, 0);
    xfer(0, 1, 8'h00, 8'h00, 0);
    xfer(0, 1, 8'h01, 8'h80, 0);
    xfer(0, 0, 8'h02, 8'h00, 0);

    // Error responses leave state untouched; TCNT is read live.
    xfer(0, 1, 8'h03, 8'hAA, 0);
    xfer(0, 1, 8'h10, 8'h55, 0);
    xfer(0, 0, 8'h10, 8'h00, 0);
    check_ports("err");
    tcnt = 8'h5A;
    xfer(0, 0, 8'h03, 8'h00, 0);

    // Randomised traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      a = (sel < 4) ? 8'(sel) : ((sel == 4) ? 8'($urandom_range(4, 255)) : 8'h10);
      d = 8'($urandom);
      tcnt = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pulse(1'($urandom), 1'($urandom));
      xfer((n % 4 == 3) ? 1 : 0, 1'($urandom), a, d, 0);
    end
    check_ports("rand");

    // Wait-state instance: abort must not commit.
    xfer(1, 1, 8'h00, 8'h3C, 0);
    @(posedge clk); #1;
    psel_d[1] = 1; penable_d[1] = 0; pwrite_d[1] = 1; paddr_d[1] = 8'h00; pwdata_d[1] = 8'h77;
    @(posedge clk); #1;
    penable_d[1] = 1;
    @(negedge clk); check("abort_rdy1", bus3.pready, 0);
    @(posedge clk); #1;
    @(negedge clk); check("abort_rdy2", bus3.pready, 0);
    @(posedge clk); #1;
    psel_d[1] = 0; penable_d[1] = 0;
    @(posedge clk); #1;
    check("abort_tdr3", tdr3, 8'h3C);
    xfer(1, 0, 8'h00, 8'h00, 0);

    // Reset in the middle of a stalled transfer.
    pulse(0, 1);
    @(posedge clk); #1;
    psel_d[1] = 1; penable_d[1] = 0; pwrite_d[1] = 1; paddr_d[1] = 8'h01; pwdata_d[1] = 8'h11;
    @(posedge clk); #1;
    penable_d[1] = 1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_pready3", bus3.pready, 0);
    check("mid_rst_prdata3", bus3.prdata, 0);
    check("mid_rst_pslverr3", bus3.pslverr, 0);
    check_ports("mid_rst");
    psel_d[1] = 0; penable_d[1] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(1, 0, 8'h01, 8'h00, 0);
    xfer(0, 0, 8'h00, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit in case a wait loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
